// File: rtl/cfg_bank_programmer_pkg.sv
// Shared types and constants for the configuration-bank programmer.
package cfg_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_e;

    localparam int DEF_BL_WIDTH     = 32;
    localparam int DEF_WL_WIDTH     = 16;
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES  = 1;

    // Widest wordline bus the helper can describe; callers cast down to WL_WIDTH.
    localparam int MAX_WL_WIDTH     = 1024;

    // One-hot wordline select for a given row.
    function automatic logic [MAX_WL_WIDTH-1:0] onehot(input int unsigned row);
        return MAX_WL_WIDTH'(1) << row;
    endfunction

endpackage

// File: rtl/cfg_bank_programmer_if.sv
// Configuration word stream (valid/ready) feeding the bank programmer.
interface cfg_bank_programmer_if #(
    parameter int BL_WIDTH = 32
) ();
    logic                cfg_valid;
    logic                cfg_ready;
    logic [BL_WIDTH-1:0] cfg_data;
    logic                cfg_last;

    modport master (output cfg_valid, output cfg_data, output cfg_last, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_data, input  cfg_last, output cfg_ready);
endinterface

// File: rtl/cfg_bank_programmer_counter.sv
// Down-counter shared by the SETUP, PULSE and HOLD phases.
module cfg_timing_counter #(
    parameter int W = 2
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/cfg_bank_programmer.sv
// Bitline/wordline writer: takes one config word per row and pulses that
// row's wordline with setup/pulse/hold framing. All outputs are flops.
module cfg_bank_programmer
    import cfg_prog_pkg::*;
#(
    parameter int BL_WIDTH     = DEF_BL_WIDTH,
    parameter int WL_WIDTH     = DEF_WL_WIDTH,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic                  prog_clk,
    input  logic                  global_resetn,
    input  logic                  start,
    cfg_bank_programmer_if.slave  cfg,
    output logic [BL_WIDTH-1:0]   bl,
    output logic [WL_WIDTH-1:0]   wl,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_T  = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int CNT_W  = $clog2(MAX_T + 1);
    localparam int ROW_W  = $clog2(WL_WIDTH);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WL_WIDTH - 1);

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [BL_WIDTH-1:0] bl_q, bl_d;
    logic [WL_WIDTH-1:0] wl_q, wl_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_val;
    logic                cnt_zero;
    logic                last_row;

    assign last_row = (row_q == LAST_ROW);

    cfg_timing_counter #(.W(CNT_W)) u_cnt (
        .gclk     (prog_clk),
        .grst_n   (global_resetn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Next-state and next-output logic; outputs are registered from the _d values.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        bl_d     = bl_q;
        wl_d     = wl_q;
        ready_d  = ready_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_DATA;
                    row_d   = '0;
                    err_d   = 1'b0;
                    ready_d = 1'b1;
                end
            end
            WAIT_DATA: begin
                if (cfg.cfg_valid && ready_q) begin
                    bl_d     = cfg.cfg_data;
                    ready_d  = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = SETUP_LD;
                    state_d  = SETUP;
                    // Framing mismatch is flagged but the row is still written.
                    if (cfg.cfg_last != last_row)
                        err_d = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    wl_d     = WL_WIDTH'(onehot(32'(row_q)));
                    cnt_load = 1'b1;
                    cnt_val  = PULSE_LD;
                    state_d  = PULSE;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    wl_d     = '0;
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    if (last_row) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        ready_d = 1'b1;
                        state_d = WAIT_DATA;
                    end
                end
            end
            DONE: begin
                bl_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers; async reset also drops wl immediately.
    always_ff @(posedge prog_clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q <= IDLE;
            row_q   <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign bl            = bl_q;
    assign wl            = wl_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_cfg_bank_programmer.sv
// Bench: two programmers (default timing and 3/1/2 timing), 4-row banks,
// compared every cycle against a timeline model of the programming sequence.
module tb_cfg_bank_programmer;
    localparam int BLW = 32;
    localparam int WLW = 4;
    localparam int S0 = 1, P0 = 2, H0 = 1;
    localparam int S1 = 3, P1 = 1, H1 = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic           start [2] = '{1'b0, 1'b0};
    logic           valid [2] = '{1'b0, 1'b0};
    logic           last  [2] = '{1'b0, 1'b0};
    logic [BLW-1:0] data  [2] = '{32'h0, 32'h0};
    logic           ready [2];
    logic           busy  [2];
    logic           done  [2];
    logic           err   [2];
    logic [BLW-1:0] bl_o  [2];
    logic [WLW-1:0] wl_o  [2];

    cfg_bank_programmer_if #(.BL_WIDTH(BLW)) if0 ();
    cfg_bank_programmer_if #(.BL_WIDTH(BLW)) if1 ();
    assign if0.cfg_valid = valid[0];
    assign if0.cfg_data  = data[0];
    assign if0.cfg_last  = last[0];
    assign ready[0]      = if0.cfg_ready;
    assign if1.cfg_valid = valid[1];
    assign if1.cfg_data  = data[1];
    assign if1.cfg_last  = last[1];
    assign ready[1]      = if1.cfg_ready;

    cfg_bank_programmer #(.BL_WIDTH(BLW), .WL_WIDTH(WLW),
        .SETUP_CYCLES(S0), .PULSE_CYCLES(P0), .HOLD_CYCLES(H0)) dut0 (
        .prog_clk(clk), .global_resetn(rstn), .start(start[0]), .cfg(if0),
        .bl(bl_o[0]), .wl(wl_o[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

    cfg_bank_programmer #(.BL_WIDTH(BLW), .WL_WIDTH(WLW),
        .SETUP_CYCLES(S1), .PULSE_CYCLES(P1), .HOLD_CYCLES(H1)) dut1 (
        .prog_clk(clk), .global_resetn(rstn), .start(start[1]), .cfg(if1),
        .bl(bl_o[1]), .wl(wl_o[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // mode: 0 idle, 1 waiting for word, 2 running row (k = cycles since handshake), 3 done
    localparam int TS [2] = '{S0, S1};
    localparam int TP [2] = '{P0, P1};
    localparam int TH [2] = '{H0, H1};
    int             m_mode [2] = '{0, 0};
    int             m_row  [2] = '{0, 0};
    int             m_k    [2] = '{0, 0};
    logic [BLW-1:0] m_bl   [2] = '{32'h0, 32'h0};
    logic           m_err  [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rstn) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                m_mode[i] <= 0; m_row[i] <= 0; m_k[i] <= 0; m_bl[i] <= '0; m_err[i] <= 1'b0;
            end else begin
                case (m_mode[i])
                    0: if (start[i]) begin m_mode[i] <= 1; m_row[i] <= 0; m_err[i] <= 1'b0; end
                    1: if (valid[i]) begin
                        m_bl[i]   <= data[i];
                        m_k[i]    <= 0;
                        m_mode[i] <= 2;
                        if (last[i] != (m_row[i] == WLW - 1)) m_err[i] <= 1'b1;
                    end
                    2: begin
                        if (m_k[i] + 1 == TS[i] + TP[i] + TH[i]) begin
                            if (m_row[i] == WLW - 1) m_mode[i] <= 3;
                            else begin m_row[i] <= m_row[i] + 1; m_mode[i] <= 1; end
                        end else m_k[i] <= m_k[i] + 1;
                    end
                    default: begin m_bl[i] <= '0; m_mode[i] <= 0; end
                endcase
            end
        end
    end

    function automatic logic [WLW-1:0] exp_wl(input int i);
        if (m_mode[i] == 2 && m_k[i] >= TS[i] && m_k[i] < TS[i] + TP[i])
            return WLW'(1) << m_row[i];
        return '0;
    endfunction

    // ---------------- per-cycle compare ----------------
    int             pulse_cnt [2] = '{0, 0};
    int             done_cnt  [2] = '{0, 0};
    logic           seen_f    [2] = '{1'b0, 1'b0};
    logic [BLW-1:0] seen_bl   [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy[%0d]", i),  32'(busy[i]),  32'(m_mode[i] != 0));
            chk($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(m_mode[i] == 1));
            chk($sformatf("done[%0d]", i),  32'(done[i]),  32'(m_mode[i] == 3));
            chk($sformatf("err[%0d]", i),   32'(err[i]),   32'(m_err[i]));
            chk($sformatf("bl[%0d]", i),    bl_o[i],       m_bl[i]);
            chk($sformatf("wl[%0d]", i),    32'(wl_o[i]),  32'(exp_wl(i)));
            chk($sformatf("wl_onehot0[%0d]", i), 32'($onehot0(wl_o[i])), 32'd1);
            if (wl_o[i] != '0) pulse_cnt[i]++;
            if (done[i]) done_cnt[i]++;
            if (wl_o[i] == 4'b0001 && !seen_f[i]) begin seen_f[i] = 1'b1; seen_bl[i] = bl_o[i]; end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Program one bank. Negative row arguments disable the corresponding feature.
    task automatic bank(input int i, input logic [31:0] w [4], input int last_row,
                        input int stall_row, input int stall_n, input int busy_start_row,
                        input int rst_row, input int exp_gap);
        int  n;
        logic got;
        pulse_cnt[i] = 0; done_cnt[i] = 0; seen_f[i] = 1'b0;
        start[i] = 1'b1; tick(); start[i] = 1'b0;
        @(negedge clk); chk("err_cleared_by_start", 32'(err[i]), 32'd0); tick();
        for (int r = 0; r < 4; r++) begin
            if (r == stall_row) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_bl", bl_o[i], w[r-1]);
                    chk("stall_wl", 32'(wl_o[i]), 32'd0);
                    chk("stall_ready", 32'(ready[i]), 32'd1);
                    tick();
                end
            end
            valid[i] = 1'b1; data[i] = w[r]; last[i] = (r == last_row);
            got = 1'b0; n = 0;
            while (!got && n < 100) begin @(negedge clk); got = ready[i]; n++; tick(); end
            valid[i] = 1'b0; data[i] = $urandom; last[i] = 1'b0;
            chk("handshake_seen", 32'(got), 32'd1);
            if (r == rst_row) begin
                n = 0; got = 1'b0;
                while (!got && n < 50) begin @(negedge clk); got = (wl_o[i] != '0); n++; if (!got) tick(); end
                chk("pulse_before_reset", 32'(got), 32'd1);
                #2 rstn = 1'b0;
                #1;
                chk("reset_wl", 32'(wl_o[i]), 32'd0);
                chk("reset_bl", bl_o[i], 32'd0);
                chk("reset_busy", 32'(busy[i]), 32'd0);
                tick(); @(posedge clk); #1 rstn = 1'b1; tick();
                return;
            end
            n = 1;
            if (r == busy_start_row) begin start[i] = 1'b1; tick(); start[i] = 1'b0; n = 2; end
            if (r < 3) begin
                got = 1'b0;
                while (!got && n < 100) begin @(negedge clk); got = ready[i]; if (!got) begin n++; tick(); end end
                chk("handshake_to_ready", 32'(n), 32'(exp_gap));
                tick();
            end
        end
        n = 0; got = 1'b0;
        while (!got && n < 50) begin @(negedge clk); got = done[i]; n++; if (!got) tick(); end
        chk("done_seen", 32'(got), 32'd1);
        tick(); tick();
        @(negedge clk);
        chk("busy_after_done", 32'(busy[i]), 32'd0);
        chk("pulse_cycles", 32'(pulse_cnt[i]), 32'(4 * TP[i]));
        chk("done_count", 32'(done_cnt[i]), 32'd1);
        chk("err_final", 32'(err[i]), 32'(last_row != 3));
        tick();
    endtask

    initial begin
        logic [31:0] w [4];
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("reset_busy0", 32'(busy[0]), 32'd0);
        chk("reset_wl0", 32'(wl_o[0]), 32'd0);
        tick();

        // basic bank
        w = '{32'hA5A5A5A5, 32'h0, 32'hFFFFFFFF, 32'h12345678};
        bank(0, w, 3, -1, 0, -1, -1, 5);
        chk("row0_bl_in_pulse", seen_bl[0], 32'hA5A5A5A5);

        // stalled source between rows 1 and 2
        w = '{$urandom, $urandom, $urandom, $urandom};
        bank(0, w, 3, 2, 7, -1, -1, 5);

        // framing error: cfg_last on row 1
        w = '{$urandom, $urandom, $urandom, $urandom};
        bank(0, w, 1, -1, 0, -1, -1, 5);

        // reset during row 2 pulse, then a clean bank from row 0 with start while busy
        w = '{$urandom, $urandom, $urandom, $urandom};
        bank(0, w, 3, -1, 0, -1, 2, 5);
        w = '{$urandom, $urandom, $urandom, $urandom};
        bank(0, w, 3, -1, 0, 1, -1, 5);

        // non-default timing
        w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        bank(1, w, 3, -1, 0, -1, -1, 7);
        chk("t_row0_bl_in_pulse", seen_bl[1], 32'h11111111);

        // randomized banks
        for (int b = 0; b < 8; b++) begin
            int inst, lr, sr;
            inst = b % 2;
            lr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3;
            sr = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : -1;
            w = '{$urandom, $urandom, $urandom, $urandom};
            bank(inst, w, lr, sr, int'($urandom_range(1, 6)), -1, -1, (inst == 0) ? 5 : 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit %0d", 500000);
        $fatal(1);
    end
endmodule
